// File: rtl/piece_pkg.sv
// Shared definitions for the active-piece controller.
//   - Default geometry (block size, well size, pixel origin, spawn column)
//   - FSM state, piece type and request-kind encodings
//   - Neighbour-mask bit -> cell offset tables
//   - Shape ROM: (piece type, rotation) -> 12-bit neighbour mask
package piece_pkg;

    localparam int SIZE_DEF      = 16;
    localparam int COLS_DEF      = 10;
    localparam int ROWS_DEF      = 20;
    localparam int X0_DEF        = 240;
    localparam int Y0_DEF        = 80;
    localparam int SPAWN_COL_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ACTIVE,
        ST_LOCK,
        ST_OVER
    } state_t;

    typedef enum logic [2:0] {
        PT_I    = 3'd0,
        PT_O    = 3'd1,
        PT_T    = 3'd2,
        PT_S    = 3'd3,
        PT_Z    = 3'd4,
        PT_L    = 3'd5,
        PT_J    = 3'd6,
        PT_NONE = 3'd7
    } piece_t;

    // What produced the candidate currently held for the collision checker;
    // decides where a rejected candidate sends the FSM.
    typedef enum logic [2:0] {
        RQ_NONE,
        RQ_SPAWN,
        RQ_ROT,
        RQ_LEFT,
        RQ_RIGHT,
        RQ_DROP
    } req_t;

    // Cell offset of each mask bit relative to the anchor cell (bit 1).
    localparam int OFF_DX [12] = '{-1, 0, 1, 2, 3, -1, 0, 1, -1, 0, 1, 0};
    localparam int OFF_DY [12] = '{ 0, 0, 0, 0, 0,  1, 1, 1,  2, 2, 2, 3};

    // L and J: the orientations whose anchor cell would need a cell two
    // columns to its left cannot be expressed in the offset table, so the
    // horizontal pose repeats on rotations 0 and 2, as I/S/Z do.
    function automatic logic [11:0] shape(input logic [2:0] typ, input logic [1:0] rot);
        logic [11:0] m;
        m = 12'h000;
        case (typ)
            PT_I: m = rot[0] ? 12'hA42 : 12'h00F;
            PT_O: m = 12'h0C6;
            PT_T: begin
                case (rot)
                    2'd0: m = 12'h047;
                    2'd1: m = 12'h262;
                    2'd2: m = 12'h0E2;
                    default: m = 12'h2C2;
                endcase
            end
            PT_S: m = rot[0] ? 12'h4C2 : 12'h066;
            PT_Z: m = rot[0] ? 12'h162 : 12'h0C3;
            PT_L: begin
                case (rot)
                    2'd1: m = 12'h642;
                    2'd3: m = 12'h243;
                    default: m = 12'h027;
                endcase
            end
            PT_J: begin
                case (rot)
                    2'd1: m = 12'h342;
                    2'd3: m = 12'h246;
                    default: m = 12'h087;
                endcase
            end
            default: m = 12'h000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/piece_fit.sv
// Combinational wall/floor checker.
//   col_i  : candidate anchor column, signed (may be -1 after a left move)
//   row_i  : candidate anchor row
//   mask_i : candidate neighbour mask
//   fits_o : 1 when every occupied cell lies in columns 0..COLS-1 and
//            rows 0..ROWS-1
module piece_fit
    import piece_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic signed [5:0]  col_i,
    input  logic        [5:0]  row_i,
    input  logic        [11:0] mask_i,
    output logic               fits_o
);

    // NOTE: fits_o gets a value before the loop so every path assigns it;
    // without that default a combinational block infers a latch.
    always_comb begin
        fits_o = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (mask_i[i]) begin
                if ((int'(col_i) + OFF_DX[i] < 0) ||
                    (int'(col_i) + OFF_DX[i] > COLS - 1) ||
                    (int'(row_i) + OFF_DY[i] > ROWS - 1)) begin
                    fits_o = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/piece_ctrl.sv
// Active-piece controller feeding the shape renderer.
//   spawn_valid/piece_type     : new piece request, accepted in IDLE only
//   mv_left/mv_right/rot_cw/drop_tick : move pulses, accepted in ACTIVE only
//   cand_valid/cand_col/cand_row/cand_mask : candidate to the stack checker
//   cand_ack/cand_ok           : checker response (cand_ok valid with ack)
//   ref_x/ref_y/mask/show      : renderer anchor (pixels), mask, visibility
//   lock                       : one-cycle pulse when the piece settles
//   game_over                  : sticky until reset; spawn hit the stack
module piece_ctrl
    import piece_pkg::*;
#(
    parameter int SIZE      = SIZE_DEF,
    parameter int COLS      = COLS_DEF,
    parameter int ROWS      = ROWS_DEF,
    parameter int X0        = X0_DEF,
    parameter int Y0        = Y0_DEF,
    parameter int SPAWN_COL = SPAWN_COL_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spawn_valid,
    input  logic [2:0]  piece_type,
    input  logic        mv_left,
    input  logic        mv_right,
    input  logic        rot_cw,
    input  logic        drop_tick,
    output logic        cand_valid,
    output logic [3:0]  cand_col,
    output logic [4:0]  cand_row,
    output logic [11:0] cand_mask,
    input  logic        cand_ack,
    input  logic        cand_ok,
    output logic [9:0]  ref_x,
    output logic [9:0]  ref_y,
    output logic [11:0] mask,
    output logic        show,
    output logic        lock,
    output logic        game_over
);

    state_t      state_q, state_d;
    req_t        req_q, req_d;
    logic [3:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [1:0]  rot_q, rot_d;
    logic [2:0]  type_q, type_d;
    logic [11:0] mask_q, mask_d;
    logic        cv_q, cv_d;
    logic [3:0]  ccol_q, ccol_d;
    logic [4:0]  crow_q, crow_d;
    logic [1:0]  crot_q, crot_d;
    logic [2:0]  ctype_q, ctype_d;
    logic [11:0] cmask_q, cmask_d;

    // Winning request and the position it would move the piece to.
    req_t               win;
    logic signed [5:0]  try_col;
    logic        [5:0]  try_row;
    logic        [1:0]  try_rot;
    logic        [11:0] try_mask;
    logic               try_fits;

    always_comb begin
        win     = RQ_NONE;
        try_col = $signed({2'b00, col_q});
        try_row = {1'b0, row_q};
        try_rot = rot_q;
        if (rot_cw) begin
            win     = RQ_ROT;
            try_rot = rot_q + 2'd1;
        end else if (mv_left) begin
            win     = RQ_LEFT;
            try_col = $signed({2'b00, col_q}) - 6'sd1;
        end else if (mv_right) begin
            win     = RQ_RIGHT;
            try_col = $signed({2'b00, col_q}) + 6'sd1;
        end else if (drop_tick) begin
            win     = RQ_DROP;
            try_row = {1'b0, row_q} + 6'd1;
        end
    end

    assign try_mask = shape(type_q, try_rot);

    piece_fit #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_fit (
        .col_i  (try_col),
        .row_i  (try_row),
        .mask_i (try_mask),
        .fits_o (try_fits)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        col_d   = col_q;
        row_d   = row_q;
        rot_d   = rot_q;
        type_d  = type_q;
        mask_d  = mask_q;
        cv_d    = cv_q;
        ccol_d  = ccol_q;
        crow_d  = crow_q;
        crot_d  = crot_q;
        ctype_d = ctype_q;
        cmask_d = cmask_q;

        case (state_q)
            ST_IDLE: begin
                if (spawn_valid && (piece_type != PT_NONE)) begin
                    ccol_d  = 4'(SPAWN_COL);
                    crow_d  = 5'd0;
                    crot_d  = 2'd0;
                    ctype_d = piece_type;
                    cmask_d = shape(piece_type, 2'd0);
                    cv_d    = 1'b1;
                    req_d   = RQ_SPAWN;
                    state_d = ST_CHECK;
                end
            end

            ST_ACTIVE: begin
                if (win != RQ_NONE) begin
                    if (try_fits) begin
                        // A fitting candidate is inside the well, so the
                        // narrowing to the register widths is lossless.
                        ccol_d  = try_col[3:0];
                        crow_d  = try_row[4:0];
                        crot_d  = try_rot;
                        ctype_d = type_q;
                        cmask_d = try_mask;
                        cv_d    = 1'b1;
                        req_d   = win;
                        state_d = ST_CHECK;
                    end else if (win == RQ_DROP) begin
                        state_d = ST_LOCK;
                    end
                end
            end

            ST_CHECK: begin
                if (cand_ack && cv_q) begin
                    cv_d = 1'b0;
                    if (cand_ok) begin
                        col_d   = ccol_q;
                        row_d   = crow_q;
                        rot_d   = crot_q;
                        type_d  = ctype_q;
                        mask_d  = cmask_q;
                        state_d = ST_ACTIVE;
                    end else begin
                        case (req_q)
                            RQ_DROP:  state_d = ST_LOCK;
                            RQ_SPAWN: state_d = ST_OVER;
                            default:  state_d = ST_ACTIVE;
                        endcase
                    end
                end
            end

            ST_LOCK: state_d = ST_IDLE;

            ST_OVER: state_d = ST_OVER;

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= RQ_NONE;
            col_q   <= 4'(SPAWN_COL);
            row_q   <= 5'd0;
            rot_q   <= 2'd0;
            type_q  <= 3'd0;
            mask_q  <= 12'h000;
            cv_q    <= 1'b0;
            ccol_q  <= 4'd0;
            crow_q  <= 5'd0;
            crot_q  <= 2'd0;
            ctype_q <= 3'd0;
            cmask_q <= 12'h000;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            col_q   <= col_d;
            row_q   <= row_d;
            rot_q   <= rot_d;
            type_q  <= type_d;
            mask_q  <= mask_d;
            cv_q    <= cv_d;
            ccol_q  <= ccol_d;
            crow_q  <= crow_d;
            crot_q  <= crot_d;
            ctype_q <= ctype_d;
            cmask_q <= cmask_d;
        end
    end

    assign cand_valid = cv_q;
    assign cand_col   = ccol_q;
    assign cand_row   = crow_q;
    assign cand_mask  = cmask_q;

    // Position only changes on commit, so the anchor naturally holds while
    // the piece is hidden.
    assign ref_x = 10'(X0 + int'(col_q) * SIZE);
    assign ref_y = 10'(Y0 + int'(row_q) * SIZE);
    assign mask  = mask_q;

    // The piece stays visible while a move is being checked; a spawn
    // candidate is not shown until the checker accepts it.
    assign show      = (state_q == ST_ACTIVE) || (state_q == ST_LOCK) ||
                       ((state_q == ST_CHECK) && (req_q != RQ_SPAWN));
    assign lock      = (state_q == ST_LOCK);
    assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_piece_ctrl.sv
module tb_piece_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spawn_valid;
    logic [2:0]  piece_type;
    logic        mv_left, mv_right, rot_cw, drop_tick;
    logic        cand_valid;
    logic [3:0]  cand_col;
    logic [4:0]  cand_row;
    logic [11:0] cand_mask;
    logic        cand_ack, cand_ok;
    logic [9:0]  ref_x, ref_y;
    logic [11:0] mask;
    logic        show, lock, game_over;

    typedef struct packed {
        logic [3:0]  col;
        logic [4:0]  row;
        logic [11:0] mask;
    } cand_t;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] mask;
    } lock_t;

    cand_t cand_exp[$];
    lock_t lock_exp[$];

    int checks = 0;
    int errors = 0;
    logic cv_prev = 1'b0;

    piece_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spawn_valid (spawn_valid),
        .piece_type  (piece_type),
        .mv_left     (mv_left),
        .mv_right    (mv_right),
        .rot_cw      (rot_cw),
        .drop_tick   (drop_tick),
        .cand_valid  (cand_valid),
        .cand_col    (cand_col),
        .cand_row    (cand_row),
        .cand_mask   (cand_mask),
        .cand_ack    (cand_ack),
        .cand_ok     (cand_ok),
        .ref_x       (ref_x),
        .ref_y       (ref_y),
        .mask        (mask),
        .show        (show),
        .lock        (lock),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation on each new candidate and on each lock.
    always @(negedge clk) begin
        if (cand_valid && !cv_prev) begin
            if (cand_exp.size() == 0) begin
                check("cand_unexpected", 32'(cand_valid), 32'd0);
            end else begin
                check("cand", 32'({cand_col, cand_row, cand_mask}), 32'(cand_exp.pop_front()));
            end
        end
        cv_prev = cand_valid;
        if (lock) begin
            if (lock_exp.size() == 0) begin
                check("lock_unexpected", 32'(lock), 32'd0);
            end else begin
                check("lock", {ref_x, ref_y, mask}, lock_exp.pop_front());
            end
        end
    end

    task automatic spawn(input logic [2:0] t);
        @(negedge clk);
        spawn_valid = 1'b1;
        piece_type  = t;
        @(negedge clk);
        spawn_valid = 1'b0;
    endtask

    task automatic req(input logic r, input logic l, input logic rt, input logic d);
        @(negedge clk);
        rot_cw = r; mv_left = l; mv_right = rt; drop_tick = d;
        @(negedge clk);
        rot_cw = 0; mv_left = 0; mv_right = 0; drop_tick = 0;
    endtask

    // Holds off for dly cycles, then answers the pending candidate.
    task automatic ack(input logic ok, input int dly);
        int n;
        n = 0;
        while (!cand_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < dly; k++) @(negedge clk);
        check("cand_valid_held", 32'(cand_valid), 32'd1);
        cand_ack = 1'b1;
        cand_ok  = ok;
        @(negedge clk);
        cand_ack = 1'b0;
        cand_ok  = 1'b0;
    endtask

    task automatic idle_outputs(input string tag);
        check({tag, "_show"},  32'(show),       32'd0);
        check({tag, "_lock"},  32'(lock),       32'd0);
        check({tag, "_cv"},    32'(cand_valid), 32'd0);
        check({tag, "_over"},  32'(game_over),  32'd0);
        check({tag, "_mask"},  32'(mask),       32'h000);
        check({tag, "_refx"},  32'(ref_x),      32'd304);
        check({tag, "_refy"},  32'(ref_y),      32'd80);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; spawn_valid = 0; piece_type = 0;
        mv_left = 0; mv_right = 0; rot_cw = 0; drop_tick = 0;
        cand_ack = 0; cand_ok = 0;
        repeat (3) @(negedge clk);
        idle_outputs("reset");
        rst_n = 1;

        // Spawn I and accept it.
        cand_exp.push_back('{4'd4, 5'd0, 12'h00F});
        spawn(3'd0);
        ack(1'b1, 0);
        check("spawn_show", 32'(show),  32'd1);
        check("spawn_refx", 32'(ref_x), 32'd304);
        check("spawn_refy", 32'(ref_y), 32'd80);
        check("spawn_mask", 32'(mask),  32'h00F);

        // Walk left to column 1, then the wall blocks the next step.
        for (int c = 4; c > 1; c--) begin
            cand_exp.push_back('{4'(c - 1), 5'd0, 12'h00F});
            req(0, 1, 0, 0);
            ack(1'b1, 0);
        end
        check("walk_refx", 32'(ref_x), 32'd256);
        req(0, 1, 0, 0);
        check("wall_no_cand", 32'(cand_valid), 32'd0);
        @(negedge clk);
        check("wall_refx", 32'(ref_x), 32'd256);

        // Drop refused by the stack -> lock at the current position.
        cand_exp.push_back('{4'd1, 5'd1, 12'h00F});
        lock_exp.push_back('{10'd256, 10'd80, 12'h00F});
        req(0, 0, 0, 1);
        ack(1'b0, 0);
        @(negedge clk);
        check("lock1_show", 32'(show), 32'd0);

        // T: rotation rejected by the stack, then accepted.
        cand_exp.push_back('{4'd4, 5'd0, 12'h047});
        spawn(3'd2);
        ack(1'b1, 0);
        check("t_mask", 32'(mask), 32'h047);
        cand_exp.push_back('{4'd4, 5'd0, 12'h262});
        req(1, 0, 0, 0);
        ack(1'b0, 3);
        check("rot_nok_mask", 32'(mask), 32'h047);
        cand_exp.push_back('{4'd4, 5'd0, 12'h262});
        req(1, 0, 0, 0);
        ack(1'b1, 0);
        check("rot_ok_mask", 32'(mask), 32'h262);

        // Left beats right and drop; rotate beats left.
        cand_exp.push_back('{4'd3, 5'd0, 12'h262});
        req(0, 1, 1, 1);
        ack(1'b1, 0);
        check("prio_refx", 32'(ref_x), 32'd288);
        cand_exp.push_back('{4'd3, 5'd0, 12'h0E2});
        req(1, 1, 0, 0);
        ack(1'b0, 0);
        check("prio_rot_mask", 32'(mask), 32'h262);
        cand_exp.push_back('{4'd3, 5'd1, 12'h262});
        lock_exp.push_back('{10'd288, 10'd80, 12'h262});
        req(0, 0, 0, 1);
        ack(1'b0, 0);
        @(negedge clk);

        // O dropped to row 18, then the floor locks it without a query.
        cand_exp.push_back('{4'd4, 5'd0, 12'h0C6});
        spawn(3'd1);
        ack(1'b1, 0);
        for (int r = 0; r < 18; r++) begin
            cand_exp.push_back('{4'd4, 5'(r + 1), 12'h0C6});
            req(0, 0, 0, 1);
            ack(1'b1, 0);
        end
        check("o_refy", 32'(ref_y), 32'd368);
        lock_exp.push_back('{10'd304, 10'd368, 12'h0C6});
        req(0, 0, 0, 1);
        check("floor_no_cand", 32'(cand_valid), 32'd0);
        check("floor_lock", 32'(lock), 32'd1);
        @(negedge clk);
        check("floor_show", 32'(show), 32'd0);
        check("floor_lock_end", 32'(lock), 32'd0);

        // Ignored requests in IDLE: type 7 spawn and move pulses.
        spawn(3'd7);
        check("type7_no_cand", 32'(cand_valid), 32'd0);
        req(1, 1, 1, 1);
        check("idle_req_no_cand", 32'(cand_valid), 32'd0);

        // Spawn blocked by the stack -> sticky game over.
        cand_exp.push_back('{4'd4, 5'd0, 12'h0C3});
        spawn(3'd4);
        ack(1'b0, 0);
        check("over_flag", 32'(game_over), 32'd1);
        check("over_show", 32'(show), 32'd0);
        spawn(3'd0);
        check("over_no_cand", 32'(cand_valid), 32'd0);
        @(negedge clk);
        check("over_sticky", 32'(game_over), 32'd1);

        // Reset clears game over; reset mid-CHECK drops cand_valid at once.
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        check("rst_over_clear", 32'(game_over), 32'd0);
        cand_exp.push_back('{4'd4, 5'd0, 12'h066});
        spawn(3'd3);
        #2 rst_n = 0;
        #1;
        idle_outputs("midrst");
        @(negedge clk);
        rst_n    = 1;
        cand_ack = 1'b1;
        cand_ok  = 1'b1;
        @(negedge clk);
        cand_ack = 1'b0;
        cand_ok  = 1'b0;
        idle_outputs("late_ack");

        // Normal operation resumes after reset.
        cand_exp.push_back('{4'd4, 5'd0, 12'h047});
        spawn(3'd2);
        ack(1'b1, 0);
        check("resume_show", 32'(show), 32'd1);
        check("resume_mask", 32'(mask), 32'h047);

        repeat (3) @(negedge clk);
        check("cand_queue_empty", 32'(cand_exp.size()), 32'd0);
        check("lock_queue_empty", 32'(lock_exp.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
